// File: rtl/mul_ext_sequencer_if.sv
// Handshake bundle between EX-stage issue logic, the multiply sequencer and the
// radix-4 multiplier.
interface mul_ext_sequencer_if #(
    parameter int unsigned TAG_W = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;

    logic             mul_start;
    logic [31:0]      mul_multiplicand;
    logic [31:0]      mul_multiplier;
    logic [63:0]      mul_product;
    logic             mul_done;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    logic             busy;

    // Sequencer view.
    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag,
        input  mul_product, mul_done,
        input  rsp_ready,
        output req_ready,
        output mul_start, mul_multiplicand, mul_multiplier,
        output rsp_valid, rsp_data, rsp_tag, rsp_err,
        output busy
    );

    // Issue logic / multiplier / consumer view.
    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag,
        output mul_product, mul_done,
        output rsp_ready,
        input  req_ready,
        input  mul_start, mul_multiplicand, mul_multiplier,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err,
        input  busy
    );
endinterface

// File: rtl/mul_ext_sequencer.sv
// RV32M multiply front-end: drives a signed 32x32 multiplier through start/done and
// corrects the signed product for MULHSU/MULHU before returning a tagged result.
module mul_ext_sequencer #(
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned TIMEOUT_CYC = 48
) (
    input  logic               clk,
    input  logic               rst,
    mul_ext_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b10;
    localparam logic [1:0] OpMulhu  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StFix,
        StResp
    } state_e;

    state_e           state_q, state_d;

    logic             armed_q;
    logic [1:0]       op_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      prod_q;
    logic [CntW-1:0]  cnt_q;
    logic [31:0]      data_q;
    logic             err_q;

    logic             accept;
    logic             timeout;
    logic [31:0]      hi;
    logic [31:0]      corr_a;
    logic [31:0]      corr_b;
    logic [31:0]      fix_data;

    // armed_q keeps req_ready low while rst is asserted and for the first cycle after.
    assign accept  = (state_q == StIdle) && armed_q && bus.req_valid;
    assign timeout = (state_q == StWait) && !bus.mul_done &&
                     (cnt_q == CntW'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (bus.mul_done) begin
                    state_d = StFix;
                end else if (timeout) begin
                    state_d = StResp;
                end
            end
            StFix:   state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.req_ready        = (state_q == StIdle) && armed_q;
        bus.mul_start        = (state_q == StIssue);
        bus.rsp_valid        = (state_q == StResp);
        bus.busy             = (state_q != StIdle);
        bus.mul_multiplicand = rs1_q;
        bus.mul_multiplier   = rs2_q;
        bus.rsp_data         = data_q;
        bus.rsp_tag          = tag_q;
        bus.rsp_err          = err_q;
    end

    // Unsigned correction: an operand with bit 31 set was read as x - 2^32 by the
    // signed multiplier, so the high word misses the other operand once per such bit.
    always_comb begin
        hi       = prod_q[63:32];
        corr_a   = rs2_q[31] ? rs1_q : 32'd0;
        corr_b   = rs1_q[31] ? rs2_q : 32'd0;
        fix_data = prod_q[31:0];
        unique case (op_q)
            OpMul:    fix_data = prod_q[31:0];
            OpMulh:   fix_data = hi;
            OpMulhsu: fix_data = hi + corr_a;
            OpMulhu:  fix_data = hi + corr_a + corr_b;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
            op_q    <= 2'b00;
            rs1_q   <= 32'd0;
            rs2_q   <= 32'd0;
            tag_q   <= '0;
            prod_q  <= 64'd0;
            cnt_q   <= '0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;

            if (accept) begin
                op_q  <= bus.req_op;
                rs1_q <= bus.req_rs1;
                rs2_q <= bus.req_rs2;
                tag_q <= bus.req_tag;
            end

            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + CntW'(1);
            end

            // done is only honoured in WAIT, so a late pulse cannot touch prod_q.
            if ((state_q == StWait) && bus.mul_done) begin
                prod_q <= bus.mul_product;
            end

            if (timeout) begin
                data_q <= 32'd0;
                err_q  <= 1'b1;
            end else if (state_q == StFix) begin
                data_q <= fix_data;
                err_q  <= 1'b0;
            end
        end
    end
endmodule
